// File: rtl/bsg_n_to_1_tagged_credit_arb_if.sv
// Handshake bundle between n valid/yumi input streams, the tagged output
// stream and the per-channel credit return path.
interface bsg_n_to_1_tagged_credit_arb_if #(
  parameter int width_p      = 8,
  parameter int num_in_p     = 4,
  parameter int tag_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
);
  logic [num_in_p-1:0]              v_i;
  logic [num_in_p-1:0][width_p-1:0] data_i;
  logic [num_in_p-1:0]              yumi_o;

  logic                    v_o;
  logic [tag_width_lp-1:0] tag_o;
  logic [width_p-1:0]      data_o;
  logic                    yumi_i;

  logic [num_in_p-1:0] credit_i;
  logic [num_in_p-1:0] credit_avail_o;

  modport master (
    output v_i, data_i, yumi_i, credit_i,
    input  yumi_o, v_o, tag_o, data_o, credit_avail_o
  );

  modport slave (
    input  v_i, data_i, yumi_i, credit_i,
    output yumi_o, v_o, tag_o, data_o, credit_avail_o
  );
endinterface

// File: rtl/bsg_n_to_1_tagged_credit_arb.sv
// Round-robin n-to-1 arbiter feeding a tagged demux FIFO; a per-channel
// credit counter keeps each downstream channel from overflowing.
module bsg_n_to_1_tagged_credit_arb #(
  parameter int width_p  = 8,
  parameter int num_in_p = 4,
  parameter int els_p    = 2,
  localparam int tag_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1,
  localparam int ctr_width_lp = $clog2(els_p + 1)
) (
  input logic clk_i,
  input logic reset_i,
  bsg_n_to_1_tagged_credit_arb_if.slave io
);

  localparam logic [ctr_width_lp-1:0] credit_max_lp = ctr_width_lp'(els_p);
  localparam logic [tag_width_lp-1:0] last_idx_lp   = tag_width_lp'(num_in_p - 1);

  logic [num_in_p-1:0][ctr_width_lp-1:0] credit_r;
  logic [tag_width_lp-1:0]               rr_ptr_r;

  logic [num_in_p-1:0]     elig;
  logic                    grant_found;
  logic [tag_width_lp-1:0] grant_idx;
  logic                    v_int;
  logic                    fire;
  logic [num_in_p-1:0]     dec;

  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      elig[i] = io.v_i[i] & (credit_r[i] != '0);
    end
  end

  // Ascending search from rr_ptr_r with an explicit wrap, so non-power-of-two
  // channel counts never index past the last channel.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < num_in_p; k++) begin
      cand = int'(rr_ptr_r) + k;
      if (cand >= num_in_p) cand = cand - num_in_p;
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = tag_width_lp'(cand);
      end
    end
  end

  assign v_int     = grant_found & ~reset_i;
  assign io.v_o    = v_int;
  assign io.tag_o  = v_int ? grant_idx : '0;
  assign io.data_o = io.data_i[grant_idx];

  // A yumi without a valid word is dropped so state stays put.
  assign fire = io.yumi_i & v_int;

  always_comb begin
    dec = '0;
    if (fire) dec[grant_idx] = 1'b1;
  end

  assign io.yumi_o = dec;

  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      io.credit_avail_o[i] = (credit_r[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_in_p; i++) credit_r[i] <= credit_max_lp;
      rr_ptr_r <= '0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        if (dec[i] && !io.credit_i[i]) begin
          credit_r[i] <= credit_r[i] - 1'b1;
        end else if (!dec[i] && io.credit_i[i] && credit_r[i] != credit_max_lp) begin
          credit_r[i] <= credit_r[i] + 1'b1;
        end
      end
      if (fire) begin
        rr_ptr_r <= (grant_idx == last_idx_lp) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.yumi_i && !v_int))
        else $error("yumi_i asserted while v_o is low");
      for (int i = 0; i < num_in_p; i++) begin
        assert (!(io.credit_i[i] && !dec[i] && credit_r[i] == credit_max_lp))
          else $error("credit overflow on channel %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_n_to_1_tagged_credit_arb.sv
// Directed bench: a 4-channel instance (els_p=2) for reset and exhaustion,
// a 3-channel instance (els_p=3) for round-robin, hold and starvation.
module tb_bsg_n_to_1_tagged_credit_arb;

  logic clk;
  logic reset;

  bsg_n_to_1_tagged_credit_arb_if #(.width_p(8), .num_in_p(4)) io4 ();
  bsg_n_to_1_tagged_credit_arb_if #(.width_p(8), .num_in_p(3)) io3 ();

  bsg_n_to_1_tagged_credit_arb #(.width_p(8), .num_in_p(4), .els_p(2)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .io(io4.slave)
  );

  bsg_n_to_1_tagged_credit_arb #(.width_p(8), .num_in_p(3), .els_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset), .io(io3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int exp_q[$];

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // One cycle on the selected instance (sel=1 -> 3-channel). Inputs are
  // applied just after the edge; yumi is only offered when v_o is high.
  task automatic cyc(input bit sel, input logic [3:0] v, input bit y, input logic [3:0] c,
                     input bit exp_v, input int exp_tag, input string nm);
    logic       ov;
    logic [1:0] otag;
    logic [7:0] od;
    logic [3:0] oy;
    int         t;
    if (sel) begin
      io3.v_i = v[2:0]; io3.credit_i = c[2:0]; io3.yumi_i = 1'b0;
    end else begin
      io4.v_i = v; io4.credit_i = c; io4.yumi_i = 1'b0;
    end
    if (y && exp_v) exp_q.push_back(exp_tag);
    #1;
    ov = sel ? io3.v_o : io4.v_o;
    if (sel) io3.yumi_i = y & ov;
    else     io4.yumi_i = y & ov;
    #1;
    otag = sel ? io3.tag_o  : io4.tag_o;
    od   = sel ? io3.data_o : io4.data_o;
    oy   = sel ? {1'b0, io3.yumi_o} : io4.yumi_o;
    chk({nm, "_v"}, 32'(ov), 32'(exp_v));
    if (exp_v) chk({nm, "_tag"}, 32'(otag), 32'(exp_tag));
    if (ov && y) begin
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fails++;
        $error("FAIL %s_unexpected_send observed=tag%0d expected=no_send", nm, otag);
      end
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk({nm, "_sb_tag"}, 32'(otag), 32'(t));
        chk({nm, "_data"}, 32'(od), 32'(8'hA0 + t));
        chk({nm, "_yumi_o"}, 32'(oy), 32'(1 << t));
      end
    end else begin
      chk({nm, "_yumi_o_idle"}, 32'(oy), 32'd0);
    end
    @(posedge clk); #1;
    if (sel) begin io3.yumi_i = 1'b0; io3.credit_i = '0; end
    else     begin io4.yumi_i = 1'b0; io4.credit_i = '0; end
  endtask

  initial begin
    reset = 1'b1;
    io4.v_i = '0; io4.yumi_i = 1'b0; io4.credit_i = '0;
    io3.v_i = '0; io3.yumi_i = 1'b0; io3.credit_i = '0;
    for (int i = 0; i < 4; i++) io4.data_i[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 3; i++) io3.data_i[i] = 8'hA0 + 8'(i);

    @(posedge clk); @(posedge clk); #1;
    io4.v_i = 4'b1111;
    #1;
    chk("rst_v_o", 32'(io4.v_o), 32'd0);
    chk("rst_yumi_o", 32'(io4.yumi_o), 32'd0);
    io4.v_i = '0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_avail4", 32'(io4.credit_avail_o), 32'hF);
    chk("rst_avail3", 32'(io3.credit_avail_o), 32'h7);
    cyc(0, 4'b0000, 0, 4'b0000, 0, 0, "idle4");

    // Credit exhaustion on channel 0 (els_p=2)
    cyc(0, 4'b0001, 1, 4'b0000, 1, 0, "exh_w0");
    cyc(0, 4'b0001, 1, 4'b0000, 1, 0, "exh_w1");
    cyc(0, 4'b0001, 1, 4'b0000, 0, 0, "exh_w2");
    chk("exh_avail", 32'(io4.credit_avail_o), 32'hE);
    cyc(0, 4'b0001, 0, 4'b0001, 0, 0, "exh_ret");
    chk("exh_avail_ret", 32'(io4.credit_avail_o), 32'hF);
    cyc(0, 4'b0001, 1, 4'b0000, 1, 0, "exh_after");
    chk("exh_avail_end", 32'(io4.credit_avail_o), 32'hE);
    io4.v_i = '0;

    // Round-robin over three channels
    for (int k = 0; k < 6; k++) cyc(1, 4'b0111, 1, 4'b0000, 1, k % 3, $sformatf("rr%0d", k));
    chk("rr_ptr_wrap", 32'(u_dut3.rr_ptr_r), 32'd0);
    cyc(1, 4'b0000, 0, 4'b0111, 0, 0, "rr_ret0");
    cyc(1, 4'b0000, 0, 4'b0111, 0, 0, "rr_ret1");
    chk("rr_avail", 32'(io3.credit_avail_o), 32'h7);

    // Hold without yumi
    for (int k = 0; k < 3; k++) cyc(1, 4'b0011, 0, 4'b0000, 1, 0, $sformatf("hold%0d", k));
    chk("hold_ptr", 32'(u_dut3.rr_ptr_r), 32'd0);
    cyc(1, 4'b0011, 1, 4'b0000, 1, 0, "hold_go0");
    cyc(1, 4'b0011, 1, 4'b0000, 1, 1, "hold_go1");

    // Simultaneous send and credit return on channel 1 at credit 1
    cyc(1, 4'b0010, 1, 4'b0000, 1, 1, "sim_pre");
    chk("sim_pre_cr", 32'(u_dut3.credit_r[1]), 32'd1);
    cyc(1, 4'b0010, 1, 4'b0010, 1, 1, "sim_both");
    chk("sim_cr", 32'(u_dut3.credit_r[1]), 32'd1);
    chk("sim_avail1", 32'(io3.credit_avail_o[1]), 32'd1);
    cyc(1, 4'b0010, 0, 4'b0000, 1, 1, "sim_elig");

    // Starve channel 2: drain it, then top up 0 and 1
    cyc(1, 4'b0100, 1, 4'b0000, 1, 2, "drain0");
    cyc(1, 4'b0100, 1, 4'b0000, 1, 2, "drain1");
    cyc(1, 4'b0100, 1, 4'b0000, 1, 2, "drain2");
    chk("drain_ptr_wrap", 32'(u_dut3.rr_ptr_r), 32'd0);
    chk("drain_avail", 32'(io3.credit_avail_o), 32'h3);
    cyc(1, 4'b0000, 0, 4'b0011, 0, 0, "topup");
    cyc(1, 4'b0111, 1, 4'b0000, 1, 0, "starve0");
    cyc(1, 4'b0111, 1, 4'b0000, 1, 1, "starve1");
    cyc(1, 4'b0111, 1, 4'b0000, 1, 0, "starve2");
    cyc(1, 4'b0111, 1, 4'b0000, 1, 1, "starve3");
    cyc(1, 4'b0111, 1, 4'b0100, 1, 0, "inject");
    cyc(1, 4'b0111, 1, 4'b0000, 1, 2, "granted2");
    cyc(1, 4'b0111, 1, 4'b0000, 0, 0, "all_empty");
    chk("all_empty_avail", 32'(io3.credit_avail_o), 32'h0);

    // Reset mid-operation refills every counter
    io3.v_i = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_avail", 32'(io3.credit_avail_o), 32'h7);
    chk("mid_rst_cr0", 32'(u_dut3.credit_r[0]), 32'd3);
    chk("mid_rst_ptr", 32'(u_dut3.rr_ptr_r), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bsg_n_to_1_tagged_credit_arb.md
Name: bsg_n_to_1_tagged_credit_arb

Overview:
Upstream feeder for a tagged 1-to-n demultiplexing FIFO. It takes num_in_p independent valid/yumi streams and round-robin arbitrates them onto one tagged stream (v/tag/data/yumi). It holds a per-channel credit counter, initialised to the downstream per-channel depth, so it never sends a word to a channel whose downstream FIFO is full. Credits come back one per dequeue on each downstream channel.

Parameters:
width_p, "inv", data width per word
num_in_p, -1, number of channels; must be 2 or more
els_p, "inv", downstream storage per channel; reset credit value, 1 or more
tag_width_lp, `BSG_SAFE_CLOG2(num_in_p), width of tag_o
ctr_width_lp, `BSG_SAFE_CLOG2(els_p+1), credit counter width

Ports:
clk_i  in  1  clock; all state changes on the rising edge
reset_i  in  1  reset, synchronous, active-high
v_i  in  num_in_p  per-channel word valid
data_i  in  num_in_p x width_p  per-channel word
yumi_o  out  num_in_p  per-channel dequeue; one-hot or zero
v_o  out  1  tagged word valid
tag_o  out  tag_width_lp  destination channel of the current word
data_o  out  width_p  word for channel tag_o
yumi_i  in  1  downstream accepts the word this cycle; legal only when v_o=1
credit_i  in  num_in_p  per-channel credit return; one credit per asserted bit per cycle
credit_avail_o  out  num_in_p  per-channel credit count is nonzero

Behaviour:
- State: credit_r[num_in_p][ctr_width_lp] and rr_ptr_r[tag_width_lp].
- Reset: credit_r[i]=els_p for all i; rr_ptr_r=0. While reset_i=1, v_o=0, yumi_o=0 and credit_i is ignored.
- Eligibility: elig[i] = v_i[i] & (credit_r[i]!=0).
- Grant:
  - Search starts at rr_ptr_r, ascending, modulo num_in_p. The first eligible channel wins (index g).
  - The path from v_i/credit_r to v_o/tag_o/data_o is combinational, with zero-cycle latency.
  - v_o = |elig. tag_o = g. data_o = data_i[g].
  - When v_o=0, tag_o and data_o are don't-care; the implementation drives tag_o=0.
- No combinational path from yumi_i to v_o, tag_o or data_o. yumi_o[g] = yumi_i; all other bits of yumi_o are 0.
- Grant is not sticky. Without yumi_i, the choice may change between cycles when a higher-priority channel becomes valid or receives credit. The downstream consumes in the same cycle it sees the word, so this is legal.
- On yumi_i:
  - credit_r[g] decrements by 1.
  - rr_ptr_r becomes g+1, wrapping num_in_p-1 to 0.
  - If num_in_p is not a power of two, the wrap is explicit, not a bit overflow.
- Without yumi_i, rr_ptr_r holds its value.
- Credit update per channel, each cycle:
  - Decrement only: credit-1.
  - credit_i[i] only: credit+1.
  - Both: unchanged.
  - Credits returned in a cycle become usable the next cycle; there is no same-cycle bypass.
- Boundaries:
  - credit_r[i]=0: channel i is ineligible even when v_i[i]=1. It does not block other channels.
  - Credit overflow (credit_i[i] with credit_r[i]=els_p and no decrement) is an error. A simulation-only assertion must fire. The counter saturates at els_p.
  - yumi_i with v_o=0 is an error. A simulation-only assertion must fire. State is unchanged.
- credit_avail_o[i] = (credit_r[i]!=0), taken from the registers.
- Reset mid-operation: all credits return to els_p on the next edge. The downstream FIFOs must be reset in the same cycle.

Test Plan:
- Reset, els_p=2, num_in_p=4: credit_avail_o=4'b1111. With v_i=0 -> v_o=0, yumi_o=0.
- Credit exhaustion: v_i=4'b0001, yumi_i=1 for 3 cycles, els_p=2 -> 2 words sent with tag_o=0. Third cycle has v_o=0, credit_avail_o[0]=0. A single credit_i[0] pulse -> v_o=1 on the following cycle.
- Round-robin fairness: num_in_p=3, all v_i=1, ample credits, yumi_i=1 every cycle -> tag sequence 0,1,2,0,1,2. yumi_o is one-hot and matches the tag each cycle.
- Hold without yumi: v_i=3'b011, yumi_i=0 for 3 cycles -> tag_o stays 0 and rr_ptr_r unchanged. Then yumi_i=1 -> next tag_o=1.
- Simultaneous send and credit return on channel 1 with credit_r[1]=1 -> credit_r[1] stays 1 and channel 1 remains eligible.
- Starved channel: credit_r[2]=0, v_i=3'b111 -> channels 0 and 1 alternate and channel 2 is never granted. Inject credit_i[2] -> channel 2 is granted within num_in_p cycles.
